rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold limit
module rr_arbiter #(
  parameter int VECT_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VECT_W-1:0] req,
  input  logic              done,
  output logic [VECT_W-1:0] grant,
  output logic              busy,
  output logic              timeout
);

  localparam int PW = (VECT_W > 1) ? $clog2(VECT_W) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [PW-1:0] LAST_IDX = PW'(VECT_W - 1);
  localparam logic [HW-1:0] LAST_CNT = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     gidx, gidx_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic [VECT_W-1:0] grant_n;
  logic              timeout_n;

  logic              found;
  logic [PW-1:0]     sel;
  logic              hold_last;
  logic              req_held;
  logic              release_now;
  logic              forced;

  // Circular scan starting at ptr: the first hit in rotation order wins.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < VECT_W; k++) begin
      idx = int'(ptr) + k;
      if (idx >= VECT_W) idx = idx - VECT_W;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign hold_last   = (hcnt == LAST_CNT);
  assign req_held    = req[gidx];
  assign release_now = done || !req_held || hold_last;
  // Timeout only flags a release the hold limit alone forced.
  assign forced      = hold_last && !done && req_held;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gidx_n    = gidx;
    hcnt_n    = hcnt;
    grant_n   = grant;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANTED;
          gidx_n  = sel;
          grant_n = VECT_W'(1) << sel;
          hcnt_n  = '0;
        end
      end
      GRANTED: begin
        if (release_now) begin
          state_n   = IDLE;
          grant_n   = '0;
          hcnt_n    = '0;
          ptr_n     = (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
          timeout_n = forced;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        hcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      hcnt    <= '0;
      grant   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gidx    <= gidx_n;
      hcnt    <= hcnt_n;
      grant   <= grant_n;
      timeout <= timeout_n;
    end
  end

  assign busy = |grant;

endmodule
